// File: rtl/avalon_slave_io.sv
// Avalon-MM slave register block: register file, GPIO latch, synchronised GPIO input
// with rising-edge capture, level interrupt, and write/read transaction counters.
module avalon_slave_io #(
    parameter int                  ADDR_SIZE     = 32,
    parameter int                  DATA_SIZE     = 32,
    parameter int                  REG_ADDR_BITS = 3,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR    = 32'h0000_0010,
    parameter int                  READ_LATENCY  = 1,
    parameter int                  GPIO_WIDTH    = 8,
    parameter logic [31:0]         ID_VALUE      = 32'hA5A5_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  avslave_chipselect,
    input  logic                  avslave_read,
    input  logic                  avslave_write,
    input  logic [ADDR_SIZE-1:0]  avslave_address,
    input  logic [DATA_SIZE-1:0]  avslave_writedata,
    output logic [DATA_SIZE-1:0]  avslave_readdata,
    output logic                  avslave_readdatavalid,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic                  irq
);

    localparam logic [REG_ADDR_BITS-1:0] REG_DATA_OUT    = REG_ADDR_BITS'(0);
    localparam logic [REG_ADDR_BITS-1:0] REG_DATA_IN     = REG_ADDR_BITS'(1);
    localparam logic [REG_ADDR_BITS-1:0] REG_EDGE        = REG_ADDR_BITS'(2);
    localparam logic [REG_ADDR_BITS-1:0] REG_IRQ_MASK    = REG_ADDR_BITS'(3);
    localparam logic [REG_ADDR_BITS-1:0] REG_SCRATCH     = REG_ADDR_BITS'(4);
    localparam logic [REG_ADDR_BITS-1:0] REG_WRITE_COUNT = REG_ADDR_BITS'(5);
    localparam logic [REG_ADDR_BITS-1:0] REG_READ_COUNT  = REG_ADDR_BITS'(6);
    localparam logic [REG_ADDR_BITS-1:0] REG_ID          = REG_ADDR_BITS'(7);

    logic                     wr_strobe_q, wr_strobe_d;
    logic                     rd_strobe_q, rd_strobe_d;
    logic [GPIO_WIDTH-1:0]    data_out_q, data_out_d;
    logic [GPIO_WIDTH-1:0]    sync1_q, sync1_d;
    logic [GPIO_WIDTH-1:0]    sync2_q, sync2_d;
    logic [GPIO_WIDTH-1:0]    sync_prev_q, sync_prev_d;
    logic [GPIO_WIDTH-1:0]    edge_q, edge_d;
    logic [GPIO_WIDTH-1:0]    mask_q, mask_d;
    logic [DATA_SIZE-1:0]     scratch_q, scratch_d;
    logic [15:0]              write_count_q, write_count_d;
    logic [15:0]              read_count_q, read_count_d;
    logic                     irq_q, irq_d;
    logic [READ_LATENCY-1:0]  pipe_valid_q, pipe_valid_d;
    logic [DATA_SIZE-1:0]     pipe_data_q [READ_LATENCY];
    logic [DATA_SIZE-1:0]     pipe_data_d [READ_LATENCY];

    logic                     hit;
    logic                     wr_acc;
    logic                     rd_acc;
    logic [REG_ADDR_BITS-1:0] reg_idx;
    logic [GPIO_WIDTH-1:0]    edge_set;
    logic [GPIO_WIDTH-1:0]    edge_clr;
    logic [DATA_SIZE-1:0]     rd_mux;

    // One accept per strobe: the strobe must be low in the previous cycle. A read
    // that coincides with a write is dropped so the write wins.
    always_comb begin
        hit         = avslave_address[ADDR_SIZE-1:REG_ADDR_BITS] == BASE_ADDR[ADDR_SIZE-1:REG_ADDR_BITS];
        reg_idx     = avslave_address[REG_ADDR_BITS-1:0];
        wr_strobe_d = avslave_chipselect & avslave_write;
        rd_strobe_d = avslave_chipselect & avslave_read;
        wr_acc      = wr_strobe_d & hit & ~wr_strobe_q;
        rd_acc      = rd_strobe_d & ~avslave_write & hit & ~rd_strobe_q;
    end

    // NOTE: every variable in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        data_out_d    = data_out_q;
        mask_d        = mask_q;
        scratch_d     = scratch_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        edge_clr      = '0;
        edge_set      = sync2_q & ~sync_prev_q;
        sync1_d       = gpio_in;
        sync2_d       = sync1_q;
        sync_prev_d   = sync2_q;

        if (wr_acc) begin
            write_count_d = write_count_q + 16'd1;
            case (reg_idx)
                REG_DATA_OUT: data_out_d = avslave_writedata[GPIO_WIDTH-1:0];
                REG_EDGE:     edge_clr   = avslave_writedata[GPIO_WIDTH-1:0];
                REG_IRQ_MASK: mask_d     = avslave_writedata[GPIO_WIDTH-1:0];
                REG_SCRATCH:  scratch_d  = avslave_writedata;
                default:      ;
            endcase
        end
        if (rd_acc) begin
            read_count_d = read_count_q + 16'd1;
        end

        // A capture arriving with a clear of the same bit survives.
        edge_d = (edge_q & ~edge_clr) | edge_set;
        irq_d  = |(edge_q & mask_q);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            REG_DATA_OUT:    rd_mux[GPIO_WIDTH-1:0] = data_out_q;
            REG_DATA_IN:     rd_mux[GPIO_WIDTH-1:0] = sync2_q;
            REG_EDGE:        rd_mux[GPIO_WIDTH-1:0] = edge_q;
            REG_IRQ_MASK:    rd_mux[GPIO_WIDTH-1:0] = mask_q;
            REG_SCRATCH:     rd_mux                 = scratch_q;
            REG_WRITE_COUNT: rd_mux[15:0]           = write_count_q;
            REG_READ_COUNT:  rd_mux[15:0]           = read_count_q;
            REG_ID:          rd_mux                 = DATA_SIZE'(ID_VALUE);
            default:         rd_mux                 = '0;
        endcase
    end

    // Read pipeline: stage 0 snapshots the register in the accept cycle; the last
    // stage is the readdata register and only reloads when a valid read reaches it.
    always_comb begin
        pipe_valid_d = (pipe_valid_q << 1) | READ_LATENCY'(rd_acc);
        pipe_data_d[0] = rd_mux;
        for (int k = READ_LATENCY - 1; k >= 1; k--) begin
            pipe_data_d[k] = pipe_data_q[k-1];
        end
        if (!pipe_valid_d[READ_LATENCY-1]) begin
            pipe_data_d[READ_LATENCY-1] = pipe_data_q[READ_LATENCY-1];
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_strobe_q   <= 1'b0;
            rd_strobe_q   <= 1'b0;
            data_out_q    <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            sync_prev_q   <= '0;
            edge_q        <= '0;
            mask_q        <= '0;
            scratch_q     <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            irq_q         <= 1'b0;
            pipe_valid_q  <= '0;
            // NOTE: the small read pipeline is reset too, so a flushed read leaves readdata at 0.
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            wr_strobe_q   <= wr_strobe_d;
            rd_strobe_q   <= rd_strobe_d;
            data_out_q    <= data_out_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync_prev_q   <= sync_prev_d;
            edge_q        <= edge_d;
            mask_q        <= mask_d;
            scratch_q     <= scratch_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            irq_q         <= irq_d;
            pipe_valid_q  <= pipe_valid_d;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_q[k] <= pipe_data_d[k];
            end
        end
    end

    assign avslave_readdata      = pipe_data_q[READ_LATENCY-1];
    assign avslave_readdatavalid = pipe_valid_q[READ_LATENCY-1];
    assign gpio_out              = data_out_q;
    assign irq                   = irq_q;

endmodule

// File: tb/tb_avalon_slave_io.sv
// Directed bench for avalon_slave_io: a READ_LATENCY=1 and a READ_LATENCY=3 instance
// share every input; each scenario task checks its own expected values.
module tb_avalon_slave_io;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [7:0]  gpio_in = '0;

    logic [31:0] rdata1, rdata3;
    logic        rvalid1, rvalid3;
    logic [7:0]  gpio_out1, gpio_out3;
    logic        irq1, irq3;

    int checks = 0;
    int errors = 0;
    int exp_wr = 0;
    int exp_rd = 0;

    always #5 clk = ~clk;

    avalon_slave_io #(.READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .avslave_chipselect(cs), .avslave_read(rd), .avslave_write(wr),
        .avslave_address(address), .avslave_writedata(writedata),
        .avslave_readdata(rdata1), .avslave_readdatavalid(rvalid1),
        .gpio_in(gpio_in), .gpio_out(gpio_out1), .irq(irq1)
    );

    avalon_slave_io #(.READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .avslave_chipselect(cs), .avslave_read(rd), .avslave_write(wr),
        .avslave_address(address), .avslave_writedata(writedata),
        .avslave_readdata(rdata3), .avslave_readdatavalid(rvalid3),
        .gpio_in(gpio_in), .gpio_out(gpio_out3), .irq(irq3)
    );

    function automatic logic is_hit(input logic [31:0] addr);
        return addr[31:3] == 29'h2;
    endfunction

    // Single-cycle write strobe, then one idle cycle.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; address = addr; writedata = data;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        if (is_hit(addr)) exp_wr++;
    endtask

    // Single-cycle read strobe; samples the L=1 result at T+1 and the L=3 result at
    // T+3, and flags any readdatavalid seen at any other of those cycles.
    task automatic bus_read(input logic [31:0] addr, output logic v1, output logic [31:0] d1,
                            output logic v3, output logic [31:0] d3, output logic stray);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; address = addr;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        v1 = rvalid1; d1 = rdata1; stray = rvalid3;
        @(negedge clk);
        stray = stray | rvalid1 | rvalid3;
        @(negedge clk);
        v3 = rvalid3; d3 = rdata3; stray = stray | rvalid1;
        if (is_hit(addr)) exp_rd++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rdata1 !== 32'h0) begin errors++; $display("FAIL reset_rdata1: got %h expected %h", rdata1, 32'h0); end
        checks++; if (rvalid1 !== 1'b0 || rvalid3 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b expected 00", rvalid1, rvalid3); end
        checks++; if (gpio_out1 !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h expected 00", gpio_out1); end
        checks++; if (irq1 !== 1'b0 || rdata3 !== 32'h0) begin errors++; $display("FAIL reset_irq_rdata3: got %b %h expected 0 0", irq1, rdata3); end
        reset = 1'b0;
    endtask

    task automatic test_read_id;
        logic v1, v3, stray; logic [31:0] d1, d3;
        bus_read(32'h17, v1, d1, v3, d3, stray);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL id_valid_t1: got %b expected 1", v1); end
        checks++; if (d1 !== 32'hA5A5_0001) begin errors++; $display("FAIL id_data: got %h expected a5a50001", d1); end
        checks++; if (v3 !== 1'b1 || d3 !== 32'hA5A5_0001) begin errors++; $display("FAIL id_l3: got %b %h expected 1 a5a50001", v3, d3); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL id_stray_valid: got %b expected 0", stray); end
        bus_read(32'h16, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h1) begin errors++; $display("FAIL read_count_after_id: got %h expected 1", d1); end
    endtask

    task automatic test_write_hold;
        logic v1, v3, stray; logic [31:0] d1, d3;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; address = 32'h10; writedata = 32'h5A;
        checks++; if (gpio_out1 !== 8'h00) begin errors++; $display("FAIL gpio_before_write: got %h expected 00", gpio_out1); end
        @(negedge clk);
        checks++; if (gpio_out1 !== 8'h5A) begin errors++; $display("FAIL gpio_t1: got %h expected 5a", gpio_out1); end
        repeat (3) @(negedge clk);
        cs = 1'b0; wr = 1'b0;
        exp_wr++;
        bus_read(32'h15, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h1) begin errors++; $display("FAIL write_count_held: got %h expected 1", d1); end
        bus_read(32'h10, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h5A) begin errors++; $display("FAIL data_out_readback: got %h expected 5a", d1); end
    endtask

    task automatic test_edge_irq;
        logic v1, v3, stray; logic [31:0] d1, d3;
        bus_write(32'h13, 32'h01);
        @(negedge clk); gpio_in = 8'h81;
        @(negedge clk);
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_g1: got %b expected 0", irq1); end
        @(negedge clk);
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_g2: got %b expected 0", irq1); end
        @(negedge clk);
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_g3: got %b expected 0", irq1); end
        cs = 1'b1; rd = 1'b1; address = 32'h12;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        exp_rd++;
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h81) begin errors++; $display("FAIL edge_at_g3: got %b %h expected 1 81", rvalid1, rdata1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL irq_g4: got %b expected 1", irq1); end
        repeat (3) @(negedge clk);
        bus_write(32'h12, 32'h01);
        @(negedge clk);
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b expected 0", irq1); end
        bus_read(32'h12, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h80) begin errors++; $display("FAIL edge_after_w1c: got %h expected 80", d1); end
    endtask

    task automatic test_set_wins;
        logic v1, v3, stray; logic [31:0] d1, d3;
        @(negedge clk); gpio_in = 8'h80;
        repeat (4) @(negedge clk);
        gpio_in = 8'h81;
        @(negedge clk);
        bus_write(32'h12, 32'h81);
        bus_read(32'h12, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h01) begin errors++; $display("FAIL set_wins_edge: got %h expected 01", d1); end
        checks++; if (irq1 !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b expected 1", irq1); end
        bus_read(32'h11, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h81) begin errors++; $display("FAIL data_in: got %h expected 81", d1); end
    endtask

    task automatic test_scratch_latency3;
        logic v1, v3, stray; logic [31:0] d1, d3;
        bus_write(32'h14, 32'hDEAD_BEEF);
        bus_read(32'h14, v1, d1, v3, d3, stray);
        checks++; if (v1 !== 1'b1 || d1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_l1: got %b %h expected 1 deadbeef", v1, d1); end
        checks++; if (v3 !== 1'b1 || d3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL scratch_l3_t3: got %b %h expected 1 deadbeef", v3, d3); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL scratch_stray_valid: got %b expected 0", stray); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); cs = 1'b1; rd = 1'b1; address = 32'h17;
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_l1_first: got %b %h expected 1 a5a50001", rvalid1, rdata1); end
        @(negedge clk); cs = 1'b1; rd = 1'b1; address = 32'h14;
        checks++; if (rvalid3 !== 1'b0) begin errors++; $display("FAIL b2b_l3_early: got %b expected 0", rvalid3); end
        @(negedge clk); cs = 1'b0; rd = 1'b0;
        checks++; if (rvalid3 !== 1'b1 || rdata3 !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_l3_first: got %b %h expected 1 a5a50001", rvalid3, rdata3); end
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_l1_second: got %b %h expected 1 deadbeef", rvalid1, rdata1); end
        @(negedge clk);
        checks++; if (rvalid3 !== 1'b0 || rdata3 !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_l3_hold: got %b %h expected 0 a5a50001", rvalid3, rdata3); end
        @(negedge clk);
        checks++; if (rvalid3 !== 1'b1 || rdata3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_l3_second: got %b %h expected 1 deadbeef", rvalid3, rdata3); end
        exp_rd += 2;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_miss;
        logic v1, v3, stray; logic [31:0] d1, d3;
        bus_read(32'h14, v1, d1, v3, d3, stray);
        bus_read(32'h20, v1, d1, v3, d3, stray);
        checks++; if (v1 !== 1'b0 || v3 !== 1'b0 || stray !== 1'b0) begin errors++; $display("FAIL miss_valid: got %b%b%b expected 000", v1, v3, stray); end
        checks++; if (rdata1 !== 32'hDEAD_BEEF || rdata3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL miss_rdata_held: got %h %h expected deadbeef", rdata1, rdata3); end
        bus_write(32'h20, 32'hFF);
        checks++; if (gpio_out1 !== 8'h5A) begin errors++; $display("FAIL miss_write_gpio: got %h expected 5a", gpio_out1); end
    endtask

    task automatic test_rw_collision;
        logic v1, v3, stray; logic [31:0] d1, d3;
        @(negedge clk); cs = 1'b1; rd = 1'b1; wr = 1'b1; address = 32'h14; writedata = 32'h1234_5678;
        @(negedge clk); cs = 1'b0; rd = 1'b0; wr = 1'b0;
        exp_wr++;
        stray = rvalid1;
        repeat (3) begin @(negedge clk); stray = stray | rvalid1 | rvalid3; end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL rw_read_ignored: got %b expected 0", stray); end
        bus_read(32'h14, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'h1234_5678) begin errors++; $display("FAIL rw_write_taken: got %h expected 12345678", d1); end
    endtask

    task automatic test_counters;
        logic v1, v3, stray; logic [31:0] d1, d3;
        logic [31:0] exp;
        bus_write(32'h17, 32'hFFFF_FFFF);
        bus_read(32'h17, v1, d1, v3, d3, stray);
        checks++; if (d1 !== 32'hA5A5_0001) begin errors++; $display("FAIL id_read_only: got %h expected a5a50001", d1); end
        exp = 32'(exp_wr);
        bus_read(32'h15, v1, d1, v3, d3, stray);
        checks++; if (d1 !== exp) begin errors++; $display("FAIL write_count: got %h expected %h", d1, exp); end
        exp = 32'(exp_rd);
        bus_read(32'h16, v1, d1, v3, d3, stray);
        checks++; if (d1 !== exp) begin errors++; $display("FAIL read_count: got %h expected %h", d1, exp); end
    endtask

    task automatic test_reset_mid_read;
        logic stray;
        @(negedge clk); cs = 1'b1; rd = 1'b1; address = 32'h17;
        @(negedge clk); cs = 1'b0; rd = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        stray = rvalid3;
        repeat (4) begin @(negedge clk); stray = stray | rvalid3; end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", stray); end
        checks++; if (rdata3 !== 32'h0) begin errors++; $display("FAIL flush_rdata: got %h expected 0", rdata3); end
        checks++; if (gpio_out1 !== 8'h00) begin errors++; $display("FAIL flush_gpio: got %h expected 00", gpio_out1); end
    endtask

    initial begin
        test_reset;
        test_read_id;
        test_write_hold;
        test_edge_irq;
        test_set_wins;
        test_scratch_latency3;
        test_back_to_back;
        test_miss;
        test_rw_collision;
        test_counters;
        test_reset_mid_read;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_slave_io.md
Name: avalon_slave_io

Overview:
- Avalon MM slave register block; the downstream consumer of the bus master's chipselect/read/write/address/writedata, and the source of its readdata.
- Provides a small word-addressed register file, a GPIO output latch, a synchronised GPIO input with rising-edge capture, an interrupt, and transaction counters.
- Master and bench use it as the reference slave to verify bus timing.

Parameters:
ADDR_SIZE, 32, Avalon address width.
DATA_SIZE, 32, readdata/writedata width (>= GPIO_WIDTH, >= 16).
REG_ADDR_BITS, 3, register index width; 2^REG_ADDR_BITS = 8 registers.
BASE_ADDR, 32'h0000_0010, word base address; low REG_ADDR_BITS bits must be 0.
READ_LATENCY, 1, accept-to-readdata cycles, legal 1..4.
GPIO_WIDTH, 8, GPIO in/out width.
ID_VALUE, 32'hA5A5_0001, constant returned by the ID register.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
avslave_chipselect  in  1  slave select
avslave_read  in  1  read strobe, may be held multiple cycles
avslave_write  in  1  write strobe, may be held multiple cycles
avslave_address  in  ADDR_SIZE  word address
avslave_writedata  in  DATA_SIZE  write data
avslave_readdata  out  DATA_SIZE  registered read data, held until the next completed read
avslave_readdatavalid  out  1  one-cycle pulse when avslave_readdata updates
gpio_in  in  GPIO_WIDTH  asynchronous external inputs
gpio_out  out  GPIO_WIDTH  driven from DATA_OUT
irq  out  1  level interrupt

Behaviour:
- One clock domain. Reset is synchronous and active-high: all registers, counters, the sync chain, edge state, pipeline, avslave_readdata, avslave_readdatavalid, gpio_out and irq go to 0.
- Address hit: avslave_address[ADDR_SIZE-1:REG_ADDR_BITS] == BASE_ADDR[ADDR_SIZE-1:REG_ADDR_BITS]. Register index = avslave_address[REG_ADDR_BITS-1:0].
- Accept logic:
  - wr_acc = chipselect & write & hit & ~wr_d, where wr_d is (chipselect & write) from the previous cycle. Exactly one accept per strobe, regardless of how long it is held.
  - rd_acc is the same, using read.
  - read and write asserted together: write is accepted, read is ignored.
  - Misses produce no accept, no readdatavalid and no counter change.
- Register map (index: name, access):
  - 0 DATA_OUT, RW, low GPIO_WIDTH bits; gpio_out = DATA_OUT and updates the cycle after wr_acc.
  - 1 DATA_IN, RO, 2-flop synchronised gpio_in, zero-extended.
  - 2 EDGE_CAPTURE, RW1C. A bit sets when sync[i] = 1 and the previous sync[i] = 0. Writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, set wins.
  - 3 IRQ_MASK, RW, low GPIO_WIDTH bits.
  - 4 SCRATCH, RW, full DATA_SIZE.
  - 5 WRITE_COUNT, RO, 16-bit; increments on every wr_acc, including writes to RO registers (those writes are otherwise ignored); wraps FFFF->0.
  - 6 READ_COUNT, RO, 16-bit; increments on rd_acc; wraps FFFF->0.
  - 7 ID, RO, ID_VALUE.
- Unused upper bits read as 0.
- Read timing:
  - Register contents are snapshotted in the rd_acc cycle T and passed through a READ_LATENCY-stage pipeline.
  - avslave_readdata updates and avslave_readdatavalid pulses in cycle T+READ_LATENCY.
  - READ_COUNT read back reflects its value before the increment.
  - avslave_readdata holds its value afterwards, and is not cleared when read drops.
- Pipeline is a shift structure; overlapping reads (re-strobed before the previous one completes) complete in order.
- irq = |(EDGE_CAPTURE & IRQ_MASK), registered, so it asserts one cycle after the contributing bit sets.
- Reset mid-transaction flushes the pipeline; no readdatavalid follows.
- No waitrequest; the slave never stalls.

Test Plan:
- Reset, then read index 7 at address 0x17 -> readdatavalid pulses at T+1, readdata = 0xA5A50001, READ_COUNT = 1.
- Write 0x5A to 0x10 with write held 4 cycles -> gpio_out = 0x5A from T+1; WRITE_COUNT = 1 (not 4); readback of 0x10 = 0x0000005A.
- gpio_in 0x00->0x81, IRQ_MASK = 0x01 -> EDGE_CAPTURE = 0x81 three cycles after the input change, irq = 1 one cycle later; write 0x01 to 0x12 -> EDGE_CAPTURE = 0x80, irq = 0.
- New rising edge on bit 0 in the same cycle as a W1C of bit 0 -> bit 0 remains 1.
- Read at address 0x20 (miss) -> no readdatavalid, readdata unchanged, counters unchanged; READ_LATENCY = 3 build: SCRATCH = 0xDEADBEEF readback valid exactly at T+3.
- Reset asserted at T+1 of a READ_LATENCY = 3 read -> no readdatavalid follows, readdata = 0.
